// File: rtl/int_sequencer_pkg.sv
// Shared definitions for the interrupt entry/exit sequencer: FSM state encoding,
// memory-port operation codes and the default interrupt vector.
package int_sequencer_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StDrainI,
      StPushH,
      StPushL,
      StPushF,
      StEnterVec,
      StDrainR,
      StPopF,
      StPopL,
      StPopH,
      StRestore
   } seq_state_e;

   localparam logic [1:0] MEMOP_NONE = 2'b00;
   localparam logic [1:0] MEMOP_PUSH = 2'b01;
   localparam logic [1:0] MEMOP_POP  = 2'b10;

   localparam logic [31:0] INT_VECTOR_DEFAULT = 32'h0000_0002;

endpackage

// File: rtl/int_sequencer.sv
// Interrupt entry/exit controller. Drains the pipeline, pushes return PC (high, low)
// and flags over the shared memory port, then vectors; RTI pops in reverse order and
// restores PC and flags. All outputs are registered and track the FSM state.
// Optional nesting: define NESTED_INT_EN to replace the in-ISR flag by a depth counter
// limited to MAX_DEPTH.
module int_sequencer
   import int_sequencer_pkg::*;
#(
   parameter int unsigned     PC_W       = 32,
   parameter int unsigned     DATA_W     = 16,
   parameter int unsigned     FLAG_W     = 3,
   parameter logic [PC_W-1:0] INT_VECTOR = INT_VECTOR_DEFAULT
`ifdef NESTED_INT_EN
   ,
   parameter int unsigned     MAX_DEPTH  = 4
`endif
) (
   input  logic              clk1,
   input  logic              reset,
   input  logic              interrupt,
   input  logic [PC_W-1:0]   pcIn,
   input  logic [FLAG_W-1:0] flagsIn,
   input  logic              pipeEmpty,
   input  logic              rtiDecoded,
   input  logic              memGnt,
   input  logic [DATA_W-1:0] memRdata,
   output logic              memReq,
   output logic [1:0]        memOp,
   output logic [DATA_W-1:0] memWdata,
   output logic              stallFetch,
   output logic              flushIF,
   output logic              pcLoad,
   output logic [PC_W-1:0]   pcOut,
   output logic              flagsLoad,
   output logic [FLAG_W-1:0] flagsOut,
   output logic              intActive,
   output logic              busy
);

   seq_state_e        state_q, state_d;
   logic              pending_q, pending_d;
   // Holds the return PC/flags on entry and collects the popped words on exit.
   logic [PC_W-1:0]   ret_pc_q, ret_pc_d;
   logic [FLAG_W-1:0] ret_f_q, ret_f_d;
   logic              enter_done, exit_done;
   logic              int_active, can_enter;

   logic              mem_req_q, mem_req_d;
   logic [1:0]        mem_op_q, mem_op_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              stall_q, stall_d;
   logic              flush_q, flush_d;
   logic              pc_load_q, pc_load_d;
   logic [PC_W-1:0]   pc_out_q, pc_out_d;
   logic              flags_load_q, flags_load_d;
   logic [FLAG_W-1:0] flags_out_q, flags_out_d;
   logic              busy_q, busy_d;

`ifdef NESTED_INT_EN
   localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH + 1);
   logic [DEPTH_W-1:0] depth_q, depth_d;

   assign int_active = (depth_q != '0);
   assign can_enter  = (depth_q < DEPTH_W'(MAX_DEPTH));

   // Nesting depth: up on vector entry, down on restore.
   always_comb begin
      depth_d = depth_q;
      if (enter_done) begin
         depth_d = depth_q + DEPTH_W'(1);
      end else if (exit_done) begin
         depth_d = depth_q - DEPTH_W'(1);
      end
   end
`else
   logic active_q, active_d;

   assign int_active = active_q;
   assign can_enter  = !active_q;

   // In-ISR flag: set on vector entry, cleared on restore.
   always_comb begin
      active_d = active_q;
      if (enter_done) begin
         active_d = 1'b1;
      end else if (exit_done) begin
         active_d = 1'b0;
      end
   end
`endif

   // Next state, holding registers, and outputs decoded from the next state.
   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q | interrupt;
      ret_pc_d   = ret_pc_q;
      ret_f_d    = ret_f_q;
      enter_done = 1'b0;
      exit_done  = 1'b0;

      case (state_q)
         StIdle: begin
            if (rtiDecoded && int_active) begin
               state_d = StDrainR;
            end else if (pending_q && can_enter) begin
               state_d = StDrainI;
            end
         end
         StDrainI: begin
            if (pipeEmpty) begin
               ret_pc_d = pcIn;
               ret_f_d  = flagsIn;
               state_d  = StPushH;
            end
         end
         StPushH:    if (memGnt) state_d = StPushL;
         StPushL:    if (memGnt) state_d = StPushF;
         StPushF:    if (memGnt) state_d = StEnterVec;
         StEnterVec: begin
            // A request arriving in this very cycle is a new one and must survive.
            pending_d  = interrupt;
            enter_done = 1'b1;
            state_d    = StIdle;
         end
         StDrainR:   if (pipeEmpty) state_d = StPopF;
         StPopF: begin
            if (memGnt) begin
               ret_f_d = memRdata[FLAG_W-1:0];
               state_d = StPopL;
            end
         end
         StPopL: begin
            if (memGnt) begin
               ret_pc_d[DATA_W-1:0] = memRdata;
               state_d              = StPopH;
            end
         end
         StPopH: begin
            if (memGnt) begin
               ret_pc_d[PC_W-1:DATA_W] = memRdata;
               state_d                 = StRestore;
            end
         end
         StRestore: begin
            exit_done = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase

      mem_req_d    = 1'b0;
      mem_op_d     = MEMOP_NONE;
      mem_wdata_d  = '0;
      flush_d      = 1'b0;
      pc_load_d    = 1'b0;
      pc_out_d     = '0;
      flags_load_d = 1'b0;
      flags_out_d  = '0;
      busy_d       = (state_d != StIdle);
      stall_d      = busy_d;

      case (state_d)
         StDrainI, StDrainR: flush_d = 1'b1;
         StPushH: begin
            mem_req_d   = 1'b1;
            mem_op_d    = MEMOP_PUSH;
            mem_wdata_d = ret_pc_d[PC_W-1:DATA_W];
         end
         StPushL: begin
            mem_req_d   = 1'b1;
            mem_op_d    = MEMOP_PUSH;
            mem_wdata_d = ret_pc_d[DATA_W-1:0];
         end
         StPushF: begin
            mem_req_d   = 1'b1;
            mem_op_d    = MEMOP_PUSH;
            mem_wdata_d = DATA_W'(ret_f_d);
         end
         StEnterVec: begin
            pc_load_d = 1'b1;
            pc_out_d  = INT_VECTOR;
         end
         StPopF, StPopL, StPopH: begin
            mem_req_d = 1'b1;
            mem_op_d  = MEMOP_POP;
         end
         StRestore: begin
            pc_load_d    = 1'b1;
            pc_out_d     = ret_pc_d;
            flags_load_d = 1'b1;
            flags_out_d  = ret_f_d;
         end
         default: ;
      endcase
   end

   // State, holding registers and registered outputs; synchronous reset.
   always_ff @(posedge clk1) begin
      if (reset) begin
         state_q      <= StIdle;
         pending_q    <= 1'b0;
         ret_pc_q     <= '0;
         ret_f_q      <= '0;
`ifdef NESTED_INT_EN
         depth_q      <= '0;
`else
         active_q     <= 1'b0;
`endif
         mem_req_q    <= 1'b0;
         mem_op_q     <= MEMOP_NONE;
         mem_wdata_q  <= '0;
         stall_q      <= 1'b0;
         flush_q      <= 1'b0;
         pc_load_q    <= 1'b0;
         pc_out_q     <= '0;
         flags_load_q <= 1'b0;
         flags_out_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         ret_pc_q     <= ret_pc_d;
         ret_f_q      <= ret_f_d;
`ifdef NESTED_INT_EN
         depth_q      <= depth_d;
`else
         active_q     <= active_d;
`endif
         mem_req_q    <= mem_req_d;
         mem_op_q     <= mem_op_d;
         mem_wdata_q  <= mem_wdata_d;
         stall_q      <= stall_d;
         flush_q      <= flush_d;
         pc_load_q    <= pc_load_d;
         pc_out_q     <= pc_out_d;
         flags_load_q <= flags_load_d;
         flags_out_q  <= flags_out_d;
         busy_q       <= busy_d;
      end
   end

   assign memReq     = mem_req_q;
   assign memOp      = mem_op_q;
   assign memWdata   = mem_wdata_q;
   assign stallFetch = stall_q;
   assign flushIF    = flush_q;
   assign pcLoad     = pc_load_q;
   assign pcOut      = pc_out_q;
   assign flagsLoad  = flags_load_q;
   assign flagsOut   = flags_out_q;
   assign intActive  = int_active;
   assign busy       = busy_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: directed scenarios with literal expectations, then random
// traffic. A sequence-level model (idle / entry / exit, each a drain step, three memory
// words and a load step) plus a stack memory emulator predicts every cycle's outputs.
module tb_int_sequencer;

   localparam logic [31:0] VEC = 32'h0000_0002;
`ifdef NESTED_INT_EN
   localparam int LIMIT = 4;
`else
   localparam int LIMIT = 1;
`endif
   localparam int K_NONE  = 0;
   localparam int K_ENTRY = 1;
   localparam int K_EXIT  = 2;

   logic        clk1 = 1'b0;
   logic        reset, interrupt, pipeEmpty, rtiDecoded, memGnt;
   logic [31:0] pcIn;
   logic [2:0]  flagsIn;
   logic [15:0] memRdata;
   logic        memReq, stallFetch, flushIF, pcLoad, flagsLoad, intActive, busy;
   logic [1:0]  memOp;
   logic [15:0] memWdata;
   logic [31:0] pcOut;
   logic [2:0]  flagsOut;

   int n_cmp  = 0;
   int n_fail = 0;

   int_sequencer dut (
      .clk1      (clk1),
      .reset     (reset),
      .interrupt (interrupt),
      .pcIn      (pcIn),
      .flagsIn   (flagsIn),
      .pipeEmpty (pipeEmpty),
      .rtiDecoded(rtiDecoded),
      .memGnt    (memGnt),
      .memRdata  (memRdata),
      .memReq    (memReq),
      .memOp     (memOp),
      .memWdata  (memWdata),
      .stallFetch(stallFetch),
      .flushIF   (flushIF),
      .pcLoad    (pcLoad),
      .pcOut     (pcOut),
      .flagsLoad (flagsLoad),
      .flagsOut  (flagsOut),
      .intActive (intActive),
      .busy      (busy)
   );

   always #5 clk1 = ~clk1;

   // Model: what the sequencer is doing this cycle, plus the stack memory contents.
   int          m_kind  = K_NONE;
   int          m_step  = 0;
   int          m_depth = 0;
   bit          m_pending = 1'b0;
   bit          m_rst = 1'b0;
   logic [31:0] m_ret_pc = '0;
   logic [2:0]  m_ret_f = '0;
   logic [15:0] m_popped [1:3];
   logic [15:0] stack [$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   function automatic logic [15:0] push_word(input int k);
      if (k == 1) return m_ret_pc[31:16];
      if (k == 2) return m_ret_pc[15:0];
      return {13'b0, m_ret_f};
   endfunction

   function automatic void model_step();
      bit pend_next;
      m_rst = reset;
      if (reset) begin
         m_kind = K_NONE; m_step = 0; m_depth = 0; m_pending = 1'b0;
         stack.delete();
         return;
      end
      pend_next = m_pending | interrupt;
      if (m_kind == K_NONE) begin
         if (rtiDecoded && m_depth > 0) begin
            m_kind = K_EXIT; m_step = 0;
         end else if (m_pending && m_depth < LIMIT) begin
            m_kind = K_ENTRY; m_step = 0;
         end
      end else if (m_step == 0) begin
         if (pipeEmpty) begin
            if (m_kind == K_ENTRY) begin
               m_ret_pc = pcIn; m_ret_f = flagsIn;
            end
            m_step = 1;
         end
      end else if (m_step <= 3) begin
         if (memGnt) begin
            if (m_kind == K_ENTRY) begin
               stack.push_back(push_word(m_step));
            end else begin
               m_popped[m_step] = memRdata;
               if (stack.size() > 0) void'(stack.pop_back());
            end
            m_step++;
         end
      end else begin
         if (m_kind == K_ENTRY) begin
            pend_next = interrupt;
            m_depth++;
         end else begin
            m_depth--;
         end
         m_kind = K_NONE;
         m_step = 0;
      end
      m_pending = pend_next;
   endfunction

   // Advance the model on each edge, then check every output just after it.
   always @(posedge clk1) begin
      bit act, mem, load;
      model_step();
      #1;
      act  = (m_kind != K_NONE);
      mem  = act && m_step >= 1 && m_step <= 3;
      load = act && m_step == 4;
      chk("busy", busy, act);
      chk("stallFetch", stallFetch, act);
      chk("flushIF", flushIF, act && m_step == 0);
      chk("memReq", memReq, mem);
      chk("memOp", memOp, !mem ? 2'b00 : (m_kind == K_ENTRY ? 2'b01 : 2'b10));
      if (mem && m_kind == K_ENTRY) chk("memWdata", memWdata, push_word(m_step));
      chk("pcLoad", pcLoad, load);
      if (load) chk("pcOut", pcOut, m_kind == K_ENTRY ? VEC : {m_popped[3], m_popped[2]});
      chk("flagsLoad", flagsLoad, load && m_kind == K_EXIT);
      if (load && m_kind == K_EXIT) chk("flagsOut", flagsOut, m_popped[1][2:0]);
      chk("intActive", intActive, m_depth > 0);
      if (m_rst) begin
         chk("rst_memWdata", memWdata, 0);
         chk("rst_pcOut", pcOut, 0);
         chk("rst_flagsOut", flagsOut, 0);
      end
   end

   // Stack memory: supplies the top word while a pop is in progress.
   function automatic void drive_rdata();
      if (m_kind == K_EXIT && m_step >= 1 && m_step <= 3 && stack.size() > 0)
         memRdata = stack[$];
      else
         memRdata = 16'($urandom);
   endfunction

   task automatic nclk();
      @(negedge clk1);
      drive_rdata();
   endtask

   task automatic run_entry(input logic [31:0] pc, input logic [2:0] f);
      pcIn = pc; flagsIn = f; pipeEmpty = 1'b1; memGnt = 1'b1; interrupt = 1'b1;
      nclk();
      interrupt = 1'b0;
      repeat (6) nclk();
   endtask

   task automatic run_rti();
      rtiDecoded = 1'b1; pipeEmpty = 1'b1; memGnt = 1'b1;
      nclk();
      rtiDecoded = 1'b0;
      repeat (5) nclk();
   endtask

   initial begin
      reset = 1'b1; interrupt = 1'b0; pipeEmpty = 1'b0; rtiDecoded = 1'b0;
      memGnt = 1'b0; pcIn = '0; flagsIn = '0; memRdata = '0;
      repeat (3) nclk();
      reset = 1'b0;
      nclk();
      chk("reset_busy", busy, 0);

      // Entry with grant tied high; pipe drains after three cycles.
      pcIn = 32'h0001_2345; flagsIn = 3'b101; memGnt = 1'b1; pipeEmpty = 1'b0;
      interrupt = 1'b1;
      nclk(); interrupt = 1'b0;
      nclk(); chk("d1_drain_flush", flushIF, 1);
      nclk(); nclk(); pipeEmpty = 1'b1;
      nclk(); chk("d1_push_hi", memWdata, 16'h0001); chk("d1_push_op", memOp, 2'b01);
      chk("d1_model_hi", push_word(m_step), 16'h0001);
      nclk(); chk("d1_push_lo", memWdata, 16'h2345);
      nclk(); chk("d1_push_f", memWdata, 16'h0005);
      nclk(); chk("d1_pcload", pcLoad, 1); chk("d1_vector", pcOut, 32'h0000_0002);
      nclk(); chk("d1_active", intActive, 1); chk("d1_stall_off", stallFetch, 0);

      // RTI with literal popped words.
      rtiDecoded = 1'b1; pipeEmpty = 1'b1;
      nclk(); rtiDecoded = 1'b0; chk("d3_drain_flush", flushIF, 1);
      nclk(); chk("d3_pop_op", memOp, 2'b10); memRdata = 16'h0003;
      nclk(); memRdata = 16'hBEEF;
      nclk(); memRdata = 16'h0010;
      nclk(); chk("d3_pcload", pcLoad, 1); chk("d3_pcout", pcOut, 32'h0010_BEEF);
      chk("d3_flagsload", flagsLoad, 1); chk("d3_flagsout", flagsOut, 3'b011);
      nclk(); chk("d3_inactive", intActive, 0); chk("d3_pcload_off", pcLoad, 0);
      chk("d3_flagsload_off", flagsLoad, 0);

      // Interrupt and RTI together while in an ISR: RTI first, then re-entry.
      run_entry(32'hCAFE_0123, 3'b010);
      rtiDecoded = 1'b1; interrupt = 1'b1;
      nclk(); rtiDecoded = 1'b0; interrupt = 1'b0;
      nclk(); chk("d4_rti_first", memOp, 2'b10);
      nclk(); nclk(); nclk();
      chk("d4_restore_pc", pcOut, 32'hCAFE_0123); chk("d4_restore_f", flagsOut, 3'b010);
      nclk(); chk("d4_idle_gap", busy, 0);
      nclk(); chk("d4_reentry", flushIF, 1);
      repeat (5) nclk();
      chk("d4_active_again", intActive, 1);
      run_rti();

      // Grant withheld for two cycles in the low-half push.
      pcIn = 32'h0001_2345; flagsIn = 3'b101; pipeEmpty = 1'b1; memGnt = 1'b1;
      interrupt = 1'b1;
      nclk(); interrupt = 1'b0;
      nclk(); nclk();
      nclk(); memGnt = 1'b0; chk("d2_lo_0", memWdata, 16'h2345);
      nclk(); chk("d2_lo_1", memWdata, 16'h2345); chk("d2_req_1", memReq, 1);
      nclk(); chk("d2_lo_2", memWdata, 16'h2345); memGnt = 1'b1;
      nclk(); chk("d2_flags", memWdata, 16'h0005);
      nclk(); chk("d2_pcload", pcLoad, 1);
      nclk();
      run_rti();

      // Reset in the middle of the low-half push.
      pcIn = 32'h0BAD_F00D; flagsIn = 3'b001; pipeEmpty = 1'b1; memGnt = 1'b1;
      interrupt = 1'b1;
      nclk(); interrupt = 1'b0;
      nclk(); nclk(); nclk();
      reset = 1'b1;
      nclk(); reset = 1'b0;
      chk("d5_busy", busy, 0); chk("d5_req", memReq, 0); chk("d5_stall", stallFetch, 0);
      chk("d5_wdata", memWdata, 0);
      repeat (4) nclk();
      chk("d5_no_pending", busy, 0);
      run_entry(32'h1234_5678, 3'b111);
      chk("d5_clean_entry", intActive, 1);
      run_rti();

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         nclk();
         interrupt  = ($urandom_range(0, 19) == 0);
         rtiDecoded = ($urandom_range(0, 9) == 0);
         pipeEmpty  = ($urandom_range(0, 9) < 6);
         memGnt     = ($urandom_range(0, 9) < 7);
         pcIn       = $urandom;
         flagsIn    = 3'($urandom);
         reset      = ($urandom_range(0, 699) == 0);
      end
      reset = 1'b0; interrupt = 1'b0; rtiDecoded = 1'b0;
      repeat (3) nclk();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
